// File: rtl/sort_engine_pkg.sv
// Shared constants and helpers for the sort engine and the blocks that feed it.
package sort_engine_pkg;

  // Default data width of the sort_engine_if word bus
  localparam int SE_DWIDTH_DEF = 8;

  // Width of the emitted-packet counter
  localparam int PKT_CNT_W = 16;

  // Sort engine capacity in words for a given address width
  function automatic int unsigned MAX_PKT_LEN(input int unsigned awidth);
    return 32'd1 << awidth;
  endfunction

endpackage

// File: rtl/sort_engine_if.sv
// Packet stream into the sort engine: data/val/sop/eop forward, ready back.
interface sort_engine_if #(
  parameter int DWIDTH = sort_engine_pkg::SE_DWIDTH_DEF
);
  logic [DWIDTH-1:0] data;
  logic              val;
  logic              sop;
  logic              eop;
  logic              ready;

  modport master (output data, output val, output sop, output eop, input ready);
  modport slave  (input data, input val, input sop, input eop, output ready);
endinterface

// File: rtl/sort_engine_pkt_framer.sv
// Frames a continuous val/ready word stream into sop/eop packets of at most
// 2**AWIDTH words. A packet closes on max length, input idle timeout or flush.
// A one-word hold stage delays each word until it is known whether it is the
// last one, so eop is always exact.
module sort_engine_pkt_framer
  import sort_engine_pkg::*;
#(
  parameter int AWIDTH  = 5,
  parameter int DWIDTH  = SE_DWIDTH_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DWIDTH-1:0]    data_i,
  input  logic                 val_i,
  output logic                 ready_o,
  input  logic                 flush_i,
  sort_engine_if.master        pkt_o,
  output logic [PKT_CNT_W-1:0] pkt_cnt_o
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [AWIDTH:0] WMAX = (AWIDTH + 1)'(MAX_PKT_LEN(AWIDTH));
  localparam logic [TW-1:0]   TMAX = TW'(TIMEOUT);

  // Hold stage
  logic              hold_val;
  logic              hold_sop;
  logic [DWIDTH-1:0] hold_data;
  logic [AWIDTH:0]   wcnt;
  logic [TW-1:0]     tmo;
  logic              flush_pend;

  // Output register
  logic              out_val;
  logic              out_sop;
  logic              out_eop;
  logic [DWIDTH-1:0] out_data;
  logic [PKT_CNT_W-1:0] pkt_cnt;

  logic out_free;
  logic accept;
  logic tmo_hit;
  logic close;

  assign out_free = !out_val || pkt_o.ready;
  assign ready_o  = !hold_val || out_free;
  assign accept   = val_i && ready_o;
  assign tmo_hit  = (TIMEOUT != 0) && (tmo == TMAX);
  assign close    = hold_val && ((wcnt == WMAX) || tmo_hit || flush_i || flush_pend);

  assign pkt_o.val  = out_val;
  assign pkt_o.sop  = out_sop;
  assign pkt_o.eop  = out_eop;
  assign pkt_o.data = out_data;
  assign pkt_cnt_o  = pkt_cnt;

  // Hold stage, timeout, flush pending, output register and packet counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_val   <= 1'b0;
      hold_sop   <= 1'b0;
      hold_data  <= '0;
      wcnt       <= '0;
      tmo        <= '0;
      flush_pend <= 1'b0;
      out_val    <= 1'b0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      out_data   <= '0;
      pkt_cnt    <= '0;
    end else begin
      if (out_val && out_eop && pkt_o.ready) begin
        pkt_cnt <= pkt_cnt + 1'b1;
      end

      if (out_free) begin
        if (hold_val) begin
          if (close) begin
            // Held word is the last one; a same-cycle input starts the next packet
            out_val    <= 1'b1;
            out_sop    <= hold_sop;
            out_eop    <= 1'b1;
            out_data   <= hold_data;
            flush_pend <= 1'b0;
            tmo        <= '0;
            if (accept) begin
              hold_data <= data_i;
              hold_sop  <= 1'b1;
              wcnt      <= (AWIDTH + 1)'(1);
            end else begin
              hold_val <= 1'b0;
              wcnt     <= '0;
            end
          end else if (accept) begin
            out_val   <= 1'b1;
            out_sop   <= hold_sop;
            out_eop   <= 1'b0;
            out_data  <= hold_data;
            hold_data <= data_i;
            hold_sop  <= 1'b0;
            wcnt      <= wcnt + 1'b1;
            tmo       <= '0;
          end else begin
            out_val <= 1'b0;
            if (tmo != TMAX) tmo <= tmo + 1'b1;
          end
        end else begin
          out_val <= 1'b0;
          if (accept) begin
            hold_val  <= 1'b1;
            hold_data <= data_i;
            hold_sop  <= 1'b1;
            wcnt      <= (AWIDTH + 1)'(1);
            tmo       <= '0;
          end
        end
      end else begin
        // Output stalled: remember a flush, keep aging the held word
        if (hold_val) begin
          if (flush_i) flush_pend <= 1'b1;
          if (tmo != TMAX) tmo <= tmo + 1'b1;
        end else if (accept) begin
          hold_val  <= 1'b1;
          hold_data <= data_i;
          hold_sop  <= 1'b1;
          wcnt      <= (AWIDTH + 1)'(1);
          tmo       <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sort_engine_pkt_framer.sv
// Self-checking bench for sort_engine_pkt_framer (AWIDTH=2, DWIDTH=8, TIMEOUT=16).
module tb_sort_engine_pkt_framer;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [7:0]  data_i;
  logic        val_i;
  logic        ready_o;
  logic        flush_i;
  logic        pkt_rdy;
  logic [15:0] pkt_cnt_o;

  int checks = 0;
  int errors = 0;

  sort_engine_if #(.DWIDTH(8)) pkt_if ();
  assign pkt_if.ready = pkt_rdy;

  sort_engine_pkt_framer #(.AWIDTH(2), .DWIDTH(8), .TIMEOUT(16)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .data_i    (data_i),
    .val_i     (val_i),
    .ready_o   (ready_o),
    .flush_i   (flush_i),
    .pkt_o     (pkt_if),
    .pkt_cnt_o (pkt_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        val;
    logic [7:0]  data;
    logic        rdy;
    logic        exp_ready;
    logic        exp_val;
    logic        exp_sop;
    logic        exp_eop;
    logic [7:0]  exp_data;
    logic [15:0] exp_cnt;
  } vec_t;

  typedef struct {
    logic       sop;
    logic       eop;
    logic [7:0] data;
  } beat_t;

  vec_t       tbl[10];
  logic [7:0] in_q[$];
  beat_t      out_q[$];
  logic       mon_en = 1'b0;
  logic       prev_stall = 1'b0;
  beat_t      prev_beat;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i   = 1'b1;
    val_i   = 1'b0;
    data_i  = '0;
    flush_i = 1'b0;
    pkt_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
  endtask

  // Random-phase monitor: scoreboard capture, ready_o rule, stall stability
  always @(negedge clk) begin
    if (mon_en) begin
      if (val_i && ready_o) in_q.push_back(data_i);
      if (pkt_if.val && pkt_rdy) out_q.push_back('{pkt_if.sop, pkt_if.eop, pkt_if.data});
      if (!ready_o) chk("rnd_ready_low_only_when_stalled", {dut.hold_val, pkt_if.val, pkt_rdy}, 3'b110);
      if (prev_stall)
        chk("rnd_stall_stable", {pkt_if.val, pkt_if.sop, pkt_if.eop, pkt_if.data},
            {1'b1, prev_beat.sop, prev_beat.eop, prev_beat.data});
      prev_stall = pkt_if.val && !pkt_rdy;
      prev_beat  = '{pkt_if.sop, pkt_if.eop, pkt_if.data};
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    //                 val data   rdy ery ev  es  ee  edata  ecnt
    tbl[0] = '{1'b1, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0};
    tbl[1] = '{1'b1, 8'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 16'd0};
    tbl[2] = '{1'b1, 8'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 16'd0};
    tbl[3] = '{1'b1, 8'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3, 16'd0};
    tbl[4] = '{1'b1, 8'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd4, 16'd0};
    tbl[5] = '{1'b1, 8'd6, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd5, 16'd1};
    tbl[6] = '{1'b1, 8'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd6, 16'd1};
    tbl[7] = '{1'b1, 8'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd7, 16'd1};
    tbl[8] = '{1'b1, 8'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd8, 16'd1};
    tbl[9] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 16'd2};

    // Reset state
    do_reset();
    chk("reset_state", {pkt_if.val, pkt_if.sop, pkt_if.eop, pkt_if.data, pkt_cnt_o, ready_o},
        {1'b0, 1'b0, 1'b0, 8'd0, 16'd0, 1'b1});

    // Nine back-to-back words: two full packets, then timeout closes [9]
    for (int i = 0; i < 10; i++) begin
      val_i = tbl[i].val; data_i = tbl[i].data; pkt_rdy = tbl[i].rdy;
      #1 chk($sformatf("tbl%0d_ready", i), ready_o, tbl[i].exp_ready);
      tick();
      if (tbl[i].exp_val)
        chk($sformatf("tbl%0d_beat", i), {pkt_if.val, pkt_if.sop, pkt_if.eop, pkt_if.data, pkt_cnt_o},
            {1'b1, tbl[i].exp_sop, tbl[i].exp_eop, tbl[i].exp_data, tbl[i].exp_cnt});
      else
        chk($sformatf("tbl%0d_idle", i), {pkt_if.val, pkt_cnt_o}, {1'b0, tbl[i].exp_cnt});
    end
    n = 1;
    while (!pkt_if.val && n < 40) begin
      tick();
      n++;
    end
    chk("timeout_latency", n, 17);
    chk("timeout_beat", {pkt_if.val, pkt_if.sop, pkt_if.eop, pkt_if.data}, {1'b1, 1'b1, 1'b1, 8'd9});
    tick();
    chk("timeout_pkt_cnt", {pkt_if.val, pkt_cnt_o}, {1'b0, 16'd3});

    // Flush on idle hold: one-beat packet the cycle after the pulse
    do_reset();
    flush_i = 1'b1;
    tick();
    chk("flush_empty_no_effect", pkt_if.val, 1'b0);
    flush_i = 1'b0; val_i = 1'b1; data_i = 8'hA5;
    tick();
    val_i = 1'b0;
    tick();
    chk("flush_wait1", pkt_if.val, 1'b0);
    tick();
    chk("flush_wait2", pkt_if.val, 1'b0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush_beat", {pkt_if.val, pkt_if.sop, pkt_if.eop, pkt_if.data}, {1'b1, 1'b1, 1'b1, 8'hA5});
    tick();
    chk("flush_pkt_cnt", {pkt_if.val, pkt_cnt_o}, {1'b0, 16'd1});

    // Flush while output is stalled: pending until ready returns
    do_reset();
    val_i = 1'b1; data_i = 8'h11;
    tick();
    data_i = 8'h22;
    tick();
    val_i = 1'b0; pkt_rdy = 1'b0; flush_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1 chk($sformatf("stall%0d_ready_o", i), ready_o, 1'b0);
      tick();
      flush_i = 1'b0;
      chk($sformatf("stall%0d_out", i), {pkt_if.val, pkt_if.sop, pkt_if.eop, pkt_if.data, dut.flush_pend},
          {1'b1, 1'b1, 1'b0, 8'h11, 1'b1});
    end
    pkt_rdy = 1'b1;
    tick();
    chk("stall_release_eop", {pkt_if.val, pkt_if.sop, pkt_if.eop, pkt_if.data, dut.flush_pend},
        {1'b1, 1'b0, 1'b1, 8'h22, 1'b0});
    tick();
    chk("stall_pkt_cnt", {pkt_if.val, pkt_cnt_o}, {1'b0, 16'd1});

    // Reset mid-packet discards everything
    do_reset();
    val_i = 1'b1; data_i = 8'h01;
    tick();
    data_i = 8'h02;
    tick();
    val_i = 1'b0;
    chk("pre_reset_beat", {pkt_if.val, pkt_if.data}, {1'b1, 8'h01});
    #2 rst_i = 1'b1;
    #1 chk("async_reset", {pkt_if.val, pkt_cnt_o, ready_o}, {1'b0, 16'd0, 1'b1});
    @(negedge clk) rst_i = 1'b0;
    tick();
    val_i = 1'b1; data_i = 8'h33;
    tick();
    data_i = 8'h44;
    tick();
    val_i = 1'b0;
    chk("post_reset_sop", {pkt_if.val, pkt_if.sop, pkt_if.eop, pkt_if.data, pkt_cnt_o},
        {1'b1, 1'b1, 1'b0, 8'h33, 16'd0});

    // Random backpressure with 200 random words
    do_reset();
    tick();
    in_q.delete(); out_q.delete();
    mon_en = 1'b1;
    n = 0;
    while (in_q.size() < 200 && n < 5000) begin
      val_i   = ($urandom_range(0, 3) != 0);
      data_i  = 8'($urandom);
      pkt_rdy = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    val_i = 1'b0;
    n = 0;
    while (out_q.size() < in_q.size() && n < 5000) begin
      pkt_rdy = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    pkt_rdy = 1'b1;
    tick(); tick();
    mon_en = 1'b0;
    chk("rnd_in_count", in_q.size(), 200);
    chk("rnd_out_count", out_q.size(), in_q.size());
    for (int i = 0; i < out_q.size() && i < in_q.size(); i++)
      chk($sformatf("rnd_beat%0d", i), {out_q[i].sop, out_q[i].eop, out_q[i].data},
          {(i % 4) == 0, (i % 4) == 3, in_q[i]});
    chk("rnd_pkt_cnt", pkt_cnt_o, 16'd50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
